// File: rtl/rip_alu_arb_if.sv
// Requester/ALU bus of the shared-ALU arbiter: issue, ALU drive and per-requester response.
interface rip_alu_arb_if #(
   parameter int NREQ  = 2,
   parameter int INSTW = 8
);
   logic                        flush;
   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0]             req_ready;
   logic [NREQ-1:0][INSTW-1:0]  req_inst;
   logic [NREQ-1:0][31:0]       req_rs1;
   logic [NREQ-1:0][31:0]       req_rs2;
   logic [NREQ-1:0][31:0]       req_pc;
   logic [NREQ-1:0][31:0]       req_imm;
   logic [INSTW-1:0]            alu_inst;
   logic [31:0]                 alu_rs1;
   logic [31:0]                 alu_rs2;
   logic [31:0]                 alu_pc;
   logic [31:0]                 alu_imm;
   logic [31:0]                 alu_rslt;
   logic [NREQ-1:0]             rsp_valid;
   logic [NREQ-1:0]             rsp_ready;
   logic [NREQ-1:0][31:0]       rsp_data;

   modport slave (
      input  flush, req_valid, req_inst, req_rs1, req_rs2, req_pc, req_imm,
      input  alu_rslt, rsp_ready,
      output req_ready, alu_inst, alu_rs1, alu_rs2, alu_pc, alu_imm,
      output rsp_valid, rsp_data
   );

   modport master (
      output flush, req_valid, req_inst, req_rs1, req_rs2, req_pc, req_imm,
      output alu_rslt, rsp_ready,
      input  req_ready, alu_inst, alu_rs1, alu_rs2, alu_pc, alu_imm,
      input  rsp_valid, rsp_data
   );
endinterface

// File: rtl/rip_alu_arb.sv
// Round-robin sharing of one registered-result ALU between NREQ requesters,
// with one outstanding op and a one-deep result buffer per requester.
module rip_alu_arb_lane (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic        grant_i,
   input  logic        cap_i,
   input  logic [31:0] rslt_i,
   input  logic        rsp_ready_i,
   output logic        busy_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o
);
   logic        busy_q, busy_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        hs;

   always_comb begin
      hs          = rsp_valid_q & rsp_ready_i;
      busy_d      = busy_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (flush_i) begin
         busy_d      = 1'b0;
         rsp_valid_d = 1'b0;
      end else begin
         if (hs) begin
            busy_d      = 1'b0;
            rsp_valid_d = 1'b0;
         end
         // capture outranks a same-edge handshake; the op stays owned
         if (cap_i) begin
            busy_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rslt_i;
         end
         if (grant_i) busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
      end else begin
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign busy_o      = busy_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
endmodule

module rip_alu_arb #(
   parameter int NREQ  = 2,
   parameter int INSTW = 8,
   parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   rip_alu_arb_if.slave  bus
);
   logic [NREQ-1:0]       busy, elig, grant;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0][31:0] rsp_data;
   logic [IDW-1:0]        gnt_id;
   logic                  gnt_any;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]        inflight_id_q, inflight_id_d;
   logic                  inflight_v_q, inflight_v_d;
   int                    idx;

   // a busy requester regains eligibility in the cycle it accepts its result
   always_comb begin
      elig = bus.req_valid & (~busy | (rsp_valid & bus.rsp_ready)) & {NREQ{~bus.flush}};
   end

   always_comb begin
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_any && elig[IDW'(idx)]) begin
            gnt_any             = 1'b1;
            gnt_id              = IDW'(idx);
            grant[IDW'(idx)]    = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      inflight_v_d  = gnt_any;
      inflight_id_d = inflight_id_q;
      if (gnt_any) begin
         rr_ptr_d      = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
         inflight_id_d = gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q      <= '0;
         inflight_v_q  <= 1'b0;
         inflight_id_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         inflight_v_q  <= inflight_v_d;
         inflight_id_q <= inflight_id_d;
      end
   end

   // idle cycles present a zero instruction so the ALU computes 0
   always_comb begin
      bus.alu_inst = '0;
      bus.alu_rs1  = 32'h0;
      bus.alu_rs2  = 32'h0;
      bus.alu_pc   = 32'h0;
      bus.alu_imm  = 32'h0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            bus.alu_inst = bus.req_inst[i];
            bus.alu_rs1  = bus.req_rs1[i];
            bus.alu_rs2  = bus.req_rs2[i];
            bus.alu_pc   = bus.req_pc[i];
            bus.alu_imm  = bus.req_imm[i];
         end
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      rip_alu_arb_lane u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush_i     (bus.flush),
         .grant_i     (grant[i]),
         .cap_i       (inflight_v_q && (inflight_id_q == IDW'(i))),
         .rslt_i      (bus.alu_rslt),
         .rsp_ready_i (bus.rsp_ready[i]),
         .busy_o      (busy[i]),
         .rsp_valid_o (rsp_valid[i]),
         .rsp_data_o  (rsp_data[i])
      );
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_rip_alu_arb.sv
// Directed plus random stimulus for rip_alu_arb, checked against a per-requester
// status model (idle / in flight / buffered) and a behavioural ALU.
module tb_rip_alu_arb;
   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_ADDI  = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h04;
   localparam logic [7:0] OP_XOR   = 8'h08;
   localparam logic [7:0] OP_AUIPC = 8'h10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rip_alu_arb_if #(.NREQ(2), .INSTW(8)) bus2 ();
   rip_alu_arb_if #(.NREQ(3), .INSTW(8)) bus3 ();

   rip_alu_arb #(.NREQ(2), .INSTW(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   rip_alu_arb #(.NREQ(3), .INSTW(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   function automatic logic [31:0] alu_f(logic [7:0] op, logic [31:0] a, logic [31:0] b,
                                         logic [31:0] pc, logic [31:0] imm);
      if (op[0]) return a + b;
      if (op[1]) return a + imm;
      if (op[2]) return a - b;
      if (op[3]) return a ^ b;
      if (op[4]) return pc + imm;
      return 32'h0;
   endfunction

   // registered-result ALU sitting behind each arbiter
   always_ff @(posedge clk) begin
      bus2.alu_rslt <= alu_f(bus2.alu_inst, bus2.alu_rs1, bus2.alu_rs2, bus2.alu_pc, bus2.alu_imm);
      bus3.alu_rslt <= alu_f(bus3.alu_inst, bus3.alu_rs1, bus3.alu_rs2, bus3.alu_pc, bus3.alu_imm);
   end

   int n_assert = 0;
   int n_fail   = 0;

   // status per requester: 0 idle, 1 in flight, 2 result buffered
   int          m_st [2], n_st [2];
   logic [31:0] m_val[2], n_val[2];
   logic [31:0] m_dat[2], n_dat[2];
   int          m_rr, n_rr;
   int          last_g;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_val[i] = 0; m_dat[i] = 0;
         n_st[i] = 0; n_val[i] = 0; n_dat[i] = 0;
      end
      m_rr = 0; n_rr = 0;
   endtask

   task automatic set_req(int i, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] pc, logic [31:0] imm);
      bus2.req_inst[i] = op;
      bus2.req_rs1[i]  = a;
      bus2.req_rs2[i]  = b;
      bus2.req_pc[i]   = pc;
      bus2.req_imm[i]  = imm;
   endtask

   // compare DUT against the model mid-cycle and prepare the model's next state
   task automatic sample();
      int g;
      int idx;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < 2; k++) begin
         idx = (m_rr + k) % 2;
         if (g < 0 && bus2.req_valid[idx] && !bus2.flush &&
             (m_st[idx] == 0 || (m_st[idx] == 2 && bus2.rsp_ready[idx])))
            g = idx;
      end
      last_g = g;
      chk("req_ready", 32'(bus2.req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
      chk("alu_inst", 32'(bus2.alu_inst), (g >= 0) ? 32'(bus2.req_inst[g]) : 32'h0);
      chk("alu_rs1",  bus2.alu_rs1, (g >= 0) ? bus2.req_rs1[g] : 32'h0);
      chk("alu_rs2",  bus2.alu_rs2, (g >= 0) ? bus2.req_rs2[g] : 32'h0);
      chk("alu_pc",   bus2.alu_pc,  (g >= 0) ? bus2.req_pc[g]  : 32'h0);
      chk("alu_imm",  bus2.alu_imm, (g >= 0) ? bus2.req_imm[g] : 32'h0);
      for (int i = 0; i < 2; i++) begin
         chk("rsp_valid", 32'(bus2.rsp_valid[i]), 32'(m_st[i] == 2));
         chk("rsp_data",  bus2.rsp_data[i], m_dat[i]);
      end
      n_st = m_st; n_val = m_val; n_dat = m_dat; n_rr = m_rr;
      if (bus2.flush) begin
         for (int i = 0; i < 2; i++) n_st[i] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 1) begin
               n_st[i] = 2; n_dat[i] = m_val[i];
            end else if (m_st[i] == 2 && bus2.rsp_ready[i]) begin
               n_st[i] = 0;
            end
         end
         if (g >= 0) begin
            n_st[g]  = 1;
            n_val[g] = alu_f(bus2.req_inst[g], bus2.req_rs1[g], bus2.req_rs2[g],
                             bus2.req_pc[g], bus2.req_imm[g]);
            n_rr     = (g + 1) % 2;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      m_st = n_st; m_val = n_val; m_dat = n_dat; m_rr = n_rr;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   initial begin
      rst_n = 1'b0;
      bus2.flush = 1'b0; bus2.req_valid = '0; bus2.rsp_ready = '0;
      bus2.req_inst = '0; bus2.req_rs1 = '0; bus2.req_rs2 = '0; bus2.req_pc = '0; bus2.req_imm = '0;
      bus3.flush = 1'b0; bus3.req_valid = '0; bus3.rsp_ready = '0;
      bus3.req_inst = '0; bus3.req_rs1 = '0; bus3.req_rs2 = '0; bus3.req_pc = '0; bus3.req_imm = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      sample();
      chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'h0);
      chk("rst_rsp_data0", bus2.rsp_data[0], 32'h0);
      advance();

      // single ADDI, two-cycle latency
      bus2.rsp_ready = 2'b11;
      set_req(0, OP_ADDI, 32'd5, 32'd0, 32'd0, 32'd7);
      bus2.req_valid = 2'b01;
      sample();
      chk("addi_ready", 32'(bus2.req_ready), 32'h1);
      chk("addi_rs1", bus2.alu_rs1, 32'd5);
      chk("addi_imm", bus2.alu_imm, 32'd7);
      advance();
      bus2.req_valid = 2'b00;
      step();
      sample();
      chk("addi_rsp_valid", 32'(bus2.rsp_valid), 32'h1);
      chk("addi_rsp_data", bus2.rsp_data[0], 32'd12);
      advance();

      // one req1 op leaves rr_ptr at 0, then drain
      set_req(1, OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
      bus2.req_valid = 2'b10;
      step();
      bus2.req_valid = 2'b00;
      repeat (3) step();

      // both requesters continuously valid and ready: strict alternation
      set_req(0, OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
      set_req(1, OP_XOR, 32'hAAAA, 32'h5555, 32'd0, 32'd0);
      bus2.req_valid = 2'b11;
      for (int c = 0; c < 6; c++) begin
         sample();
         chk("alt_grant", 32'(bus2.req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         chk("alt_alu_busy", 32'(|bus2.alu_inst), 32'h1);
         if (c >= 2) chk("alt_rsp_valid", 32'(bus2.rsp_valid), (c % 2 == 0) ? 32'h1 : 32'h2);
         advance();
      end
      bus2.req_valid = 2'b00;
      repeat (3) step();

      // SUB result held while requester stalls, re-grant on accept
      set_req(0, OP_SUB, 32'd10, 32'd3, 32'd0, 32'd0);
      bus2.rsp_ready = 2'b10;
      bus2.req_valid = 2'b01;
      sample();
      chk("sub_ready", 32'(bus2.req_ready), 32'h1);
      advance();
      step();
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("hold_ready0", 32'(bus2.req_ready[0]), 32'h0);
         chk("hold_valid0", 32'(bus2.rsp_valid[0]), 32'h1);
         chk("hold_data0", bus2.rsp_data[0], 32'd7);
         advance();
      end
      bus2.rsp_ready = 2'b11;
      sample();
      chk("regrant_ready", 32'(bus2.req_ready), 32'h1);
      advance();
      bus2.req_valid = 2'b00;
      repeat (3) step();

      // flush the cycle after a req1 grant
      set_req(1, OP_AUIPC, 32'd0, 32'd0, 32'd100, 32'd4);
      bus2.req_valid = 2'b10;
      sample();
      chk("pre_flush_grant", 32'(bus2.req_ready), 32'h2);
      advance();
      bus2.flush = 1'b1;
      bus2.req_valid = 2'b11;
      sample();
      chk("flush_no_grant", 32'(bus2.req_ready), 32'h0);
      advance();
      bus2.flush = 1'b0;
      bus2.req_valid = 2'b10;
      sample();
      chk("flush_rsp_valid1", 32'(bus2.rsp_valid[1]), 32'h0);
      chk("post_flush_grant", 32'(bus2.req_ready), 32'h2);
      advance();
      bus2.req_valid = 2'b00;
      repeat (3) step();

      // asynchronous reset with one result buffered and one in flight
      bus2.rsp_ready = 2'b00;
      set_req(0, OP_ADD, 32'd20, 32'd22, 32'd0, 32'd0);
      bus2.req_valid = 2'b01;
      step();
      bus2.req_valid = 2'b10;
      step();
      bus2.req_valid = 2'b00;
      sample();
      chk("pre_rst_valid0", 32'(bus2.rsp_valid[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(bus2.rsp_valid), 32'h0);
      chk("arst_rsp_data0", bus2.rsp_data[0], 32'h0);
      chk("arst_rsp_data1", bus2.rsp_data[1], 32'h0);
      chk("arst_req_ready", 32'(bus2.req_ready), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus2.rsp_ready = 2'b11;
      for (int c = 0; c < 3; c++) begin
         sample();
         chk("post_rst_no_valid", 32'(bus2.rsp_valid), 32'h0);
         advance();
      end

      // NREQ=3 wrap: grants 2, 0, 2
      bus3.rsp_ready = 3'b111;
      bus3.req_valid = 3'b100;
      sample();
      chk("n3_grant_a", 32'(bus3.req_ready), 32'h4);
      advance();
      bus3.req_valid = 3'b101;
      sample();
      chk("n3_grant_b", 32'(bus3.req_ready), 32'h1);
      advance();
      sample();
      chk("n3_grant_c", 32'(bus3.req_ready), 32'h4);
      advance();
      bus3.req_valid = 3'b000;

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++)
            set_req(i, 8'(1 << $urandom_range(0, 4)), $urandom, $urandom, $urandom, $urandom);
         bus2.req_valid = 2'($urandom_range(0, 3));
         bus2.rsp_ready = 2'($urandom_range(0, 3));
         bus2.flush     = ($urandom_range(0, 19) == 0);
         step();
      end
      bus2.flush = 1'b0;
      bus2.req_valid = 2'b00;
      bus2.rsp_ready = 2'b11;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
